// File: rtl/bf16_mult_pipe.sv
// bf16_mult_pipe -- two-stage bf16 multiplier front end.
//
// Stage 1 registers the product sign, the biased exponent sum
// (a_e + b_e - 127, 10-bit signed) and the operand mantissas, together with
// "an operand is zero" and "an operand is inf/nan" flags. Stage 2 forms the
// 8x8 mantissa product and normalises it by at most one place. It also
// applies flush-to-zero and overflow clamping, then holds the result until
// downstream takes it.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. A producer keeps valid and its data stable until
// that transfer. Ready may depend combinationally on the consumer's ready.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operand pair accepted this cycle when in_valid is high
//   a_in,b_in  bf16 operands {sign, exp[7:0], mant[6:0]}
//   out_valid  product fields valid
//   out_ready  downstream accepts the product
//   out_s      product sign
//   out_e      biased exponent; bit 8 flags overflow (9'h100)
//   out_m      raw mantissa product, leading one at bit 14 when nonzero
//   ovf_cnt    saturating count of overflow results transferred (stats build)
//   ftz_cnt    saturating count of flushed results transferred (stats build)
//
// Optional feature macro: BF16_MULT_STATS_EN adds ovf_cnt/ftz_cnt.

module bf16_mult_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [8:0]  out_e,
  output logic [15:0] out_m
`ifdef BF16_MULT_STATS_EN
  ,
  output logic [15:0] ovf_cnt,
  output logic [15:0] ftz_cnt
`endif
);

  // Held low by reset and set on the first edge after release. This keeps
  // in_ready low throughout reset, even though stage 1 is empty then.
  logic              ready_en;

  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic              s1_inf;
  logic signed [9:0] s1_esum;
  logic [6:0]        s1_am;
  logic [6:0]        s1_bm;

  logic              s2_adv;
  logic              in_fire;

  logic [15:0]       prod;
  logic [15:0]       norm_m;
  logic signed [9:0] adj_esum;
  logic [8:0]        next_e;
  logic [15:0]       next_m;

  // Stage 2 can take new data when it is empty or is handing off this cycle.
  // Stage 1 always moves into stage 2 when stage 2 can take it.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = ready_en && (!s1_valid || s2_adv);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    prod     = {8'd0, 1'b1, s1_am} * {8'd0, 1'b1, s1_bm};
    norm_m   = prod;
    adj_esum = s1_esum;
    // The product of two [1,2) significands lies in [1,4). When it reaches
    // 2, shift it back so the leading one sits at bit 14.
    if (prod[15]) begin
      norm_m   = {1'b0, prod[15:1]};
      adj_esum = s1_esum + 10'sd1;
    end

    next_e = {1'b0, adj_esum[7:0]};
    next_m = norm_m;
    // Inf/nan operands always overflow, even when multiplied by zero.
    // Otherwise zero operands and underflow flush. Exponent overflow is
    // checked after that; it cannot coincide with esum <= 0.
    if (s1_inf) begin
      next_e = 9'h100;
      next_m = 16'h0000;
    end else if (s1_zero || adj_esum <= 10'sd0) begin
      next_e = 9'h000;
      next_m = 16'h0000;
    end else if (adj_esum >= 10'sd255) begin
      next_e = 9'h100;
      next_m = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_esum   <= 10'sd0;
      s1_am     <= 7'd0;
      s1_bm     <= 7'd0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= 9'd0;
      out_m     <= 16'd0;
    end else begin
      ready_en <= 1'b1;

      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sign  <= a_in[15] ^ b_in[15];
        s1_zero  <= (a_in[14:7] == 8'd0) || (b_in[14:7] == 8'd0);
        s1_inf   <= (a_in[14:7] == 8'hFF) || (b_in[14:7] == 8'hFF);
        s1_esum  <= $signed({2'b00, a_in[14:7]}) + $signed({2'b00, b_in[14:7]})
                    - 10'sd127;
        s1_am    <= a_in[6:0];
        s1_bm    <= b_in[6:0];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_s <= s1_sign;
          out_e <= next_e;
          out_m <= next_m;
        end
      end
    end
  end

`ifdef BF16_MULT_STATS_EN
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  // A flushed result is the only way out_e can be zero. Normal results have
  // an exponent in 1..254, and overflow results are 9'h100.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 16'd0;
      ftz_cnt <= 16'd0;
    end else if (out_fire) begin
      if (out_e[8] && ovf_cnt != 16'hFFFF) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (out_e == 9'd0 && ftz_cnt != 16'hFFFF) begin
        ftz_cnt <= ftz_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bf16_mult_pipe.sv
// tb_bf16_mult_pipe -- self-checking bench for bf16_mult_pipe.
// Structure: the clock/reset block, driver tasks, a negedge scoreboard that
// uses an arithmetic reference model, and one directed initial sequence.
// Inputs change 1 time unit after a rising edge and are sampled at falling edges.

module tb_bf16_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [8:0]  out_e;
  logic [15:0] out_m;
`ifdef BF16_MULT_STATS_EN
  logic [15:0] ovf_cnt;
  logic [15:0] ftz_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int m_ovf    = 0;
  int m_ftz    = 0;

  // Expected results in acceptance order: {sign, exp[8:0], mant[15:0]}
  logic [25:0] exp_q[$];

  bf16_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_m     (out_m)
`ifdef BF16_MULT_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .ftz_cnt   (ftz_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Works from the bf16 field values with plain integer arithmetic.
  function automatic logic [25:0] model(input logic [15:0] a, input logic [15:0] b);
    int ae, be, am, bm, p, e;
    logic s;
    s  = a[15] ^ b[15];
    ae = int'(a[14:7]);
    be = int'(b[14:7]);
    am = 128 + int'(a[6:0]);
    bm = 128 + int'(b[6:0]);
    p  = am * bm;
    e  = ae + be - 127;
    if (p >= 32768) begin
      p = p / 2;
      e = e + 1;
    end
    if (ae == 255 || be == 255) return {s, 9'h100, 16'h0000};
    if (ae == 0 || be == 0 || e <= 0) return {s, 9'h000, 16'h0000};
    if (e >= 255) return {s, 9'h100, 16'h0000};
    return {s, 9'(e), 16'(p)};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("sb_sign", 32'(out_s), 32'(exp_q[0][25]));
          check("sb_exp",  32'(out_e), 32'(exp_q[0][24:16]));
          check("sb_mant", 32'(out_m), 32'(exp_q[0][15:0]));
          if (out_ready) begin
            if (exp_q[0][24] && m_ovf < 65535) m_ovf++;
            if (exp_q[0][24:16] == 9'd0 && m_ftz < 65535) m_ftz++;
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until it is accepted (bounded wait)
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic hs;
    int   n;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    hs       = 1'b0;
    n        = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      step();
      n++;
    end
    if (!hs) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Send one pair into an idle pipe. Check the two-cycle latency and the
  // result fields against constants.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [8:0] e, input logic [15:0] m);
    int n;
    out_ready = 1'b1;
    send(a, b);
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    check({tag, "_s"}, 32'(out_s), 32'(s));
    check({tag, "_e"}, 32'(out_e), 32'(e));
    check({tag, "_m"}, 32'(out_m), 32'(m));
    step();
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:7] = 8'd0;
      1: v[14:7] = 8'd255;
      2: v[14:7] = 8'd1;
      3: v[14:7] = 8'd254;
      4: v[14:7] = 8'($urandom_range(58, 70));
      5: v[14:7] = 8'($urandom_range(185, 197));
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] sa[8];
    logic [15:0] sb[8];
    logic        hs;
    logic        saw_low;
    int          sent;
    int          cyc;
    int          base;
    int          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = 16'h0;
    b_in      = 16'h0;
    out_ready = 1'b0;

    // Reset state before any clock edge
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_s",     32'(out_s),     32'd0);
    check("rst_out_e",     32'(out_e),     32'd0);
    check("rst_out_m",     32'(out_m),     32'd0);
    step();
    check("rst_in_ready_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready_pre", 32'(in_ready), 32'd0);
    step();
    check("release_in_ready_post", 32'(in_ready), 32'd1);
`ifdef BF16_MULT_STATS_EN
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("rst_ftz_cnt", 32'(ftz_cnt), 32'd0);
`endif

    // Directed vectors
    directed("one_x_two",   16'h3F80, 16'h4000, 1'b0, 9'd128, 16'h4000);
    directed("onehalf_sq",  16'h3FC0, 16'h3FC0, 1'b0, 9'd128, 16'h4800);
    directed("overflow",    16'h7F00, 16'h7F00, 1'b0, 9'h100, 16'h0000);
    directed("underflow",   16'h0080, 16'h0080, 1'b0, 9'h000, 16'h0000);
    directed("neg_zero",    16'h8000, 16'h3F80, 1'b1, 9'h000, 16'h0000);
    directed("inf_x_zero",  16'h7F80, 16'h0000, 1'b0, 9'h100, 16'h0000);
    directed("neg_product", 16'hC000, 16'h3FC0, 1'b1, 9'd128, 16'h6000);
`ifdef BF16_MULT_STATS_EN
    check("dir_ovf_cnt", 32'(ovf_cnt), 32'd2);
    check("dir_ftz_cnt", 32'(ftz_cnt), 32'd2);
`endif

    // Stream 8 pairs back to back with out_ready low in cycles 3-6
    for (int i = 0; i < 8; i++) begin
      sa[i] = rand_op();
      sb[i] = rand_op();
    end
    base    = xfers;
    sent    = 0;
    cyc     = 0;
    saw_low = 1'b0;
    while ((sent < 8 || exp_q.size() != 0) && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) begin
        in_valid = 1'b1;
        a_in     = sa[sent];
        b_in     = sb[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && !in_ready) saw_low = 1'b1;
      hs = in_valid && in_ready;
      step();
      if (hs) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_sent",        32'(sent),         32'd8);
    check("stream_emitted",     32'(xfers - base), 32'd8);
    check("stream_backpressure", 32'(saw_low),     32'd1);
    check("stream_drained",     32'(exp_q.size()), 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    send(16'h3F80, 16'h3F80);
    send(16'h4040, 16'h4000);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_out_e",     32'(out_e),     32'd0);
    check("midrst_out_m",     32'(out_m),     32'd0);
    exp_q.delete();
    m_ovf = 0;
    m_ftz = 0;
    step();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      step();
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
`ifdef BF16_MULT_STATS_EN
    check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

    // Randomized traffic with random back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        a_in     = rand_op();
        b_in     = rand_op();
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      step();
      if (hs) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 32'(sent), 32'd300);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
`ifdef BF16_MULT_STATS_EN
    check("final_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("final_ftz_cnt", 32'(ftz_cnt), 32'(m_ftz));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf16_mult_pipe.md
BF16_MULT_PIPE -- requirements
Module: bf16_mult_pipe

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operand pair this cycle.
REQ-006 a_in  input  16  bf16 operand A: sign[15], exp[14:7], mant[6:0].
REQ-007 b_in  input  16  bf16 operand B, same format.
REQ-008 out_valid  output  1  product fields valid.
REQ-009 out_ready  input  1  downstream normalizer accepts product.
REQ-010 out_s  output  1  product sign.
REQ-011 out_e  output  9  biased product exponent; bit 8 = overflow flag.
REQ-012 out_m  output  16  raw mantissa product; leading one at bit 14 for nonzero results.
REQ-013 ovf_cnt, ftz_cnt  output  16 each  event counters (present only under REQ-030).

Function
REQ-014 SHALL be a two-stage valid/ready pipeline (S1 operand/exponent, S2 product); latency 2 cycles from accepting a pair to out_valid with out_ready held high.
REQ-015 A transfer SHALL occur when valid and ready are both high on the same edge; throughput 1 pair/cycle with no stall.
REQ-016 in_ready SHALL be high when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or S2 transfers out.
REQ-017 Under out_ready low with S2 full, S2 contents and out_* SHALL hold stable; no pair is dropped or duplicated.
REQ-018 S1 SHALL register sign = a[15]^b[15] and esum = a_e + b_e - 127 as 10-bit signed.
REQ-019 S2 SHALL compute p = {1,a_m} x {1,b_m} (8x8 -> 16 bits); if p[15]=1, out_m = p>>1 and esum incremented by 1; else out_m = p.
REQ-020 Zero/flush: if either exponent is 0, or adjusted esum <= 0, out_e = 0, out_m = 0, out_s = computed sign (flush-to-zero, no subnormals).
REQ-021 Overflow: if either exponent is 255, or adjusted esum >= 255, out_e = 9'h100, out_m = 0.
REQ-022 Otherwise out_e = {0, esum[7:0]}; REQ-020 has priority over REQ-021 only when one operand is zero and neither is 255.
REQ-023 Simultaneous input accept and output transfer in one cycle SHALL both complete.

Reset
REQ-024 rst_n low SHALL asynchronously clear S1/S2 valid bits, out_valid = 0, out_s = 0, out_e = 0, out_m = 0.
REQ-025 in_ready SHALL be 0 while rst_n is low and 1 on the first edge after release.
REQ-026 Reset mid-operation SHALL discard in-flight pairs; no out_valid until a new pair is accepted.
REQ-027 Counters (if present) SHALL reset to 0.

Configuration
REQ-028 Feature macro: BF16_MULT_STATS_EN.
REQ-029 Without it: ovf_cnt/ftz_cnt ports and counter logic absent.
REQ-030 With it: ovf_cnt increments on each output transfer with out_e[8]=1, ftz_cnt on each output transfer flushed per REQ-020; both saturate at 16'hFFFF; datapath timing unchanged.

Verification
REQ-031 a=16'h3F80 (1.0), b=16'h4000 (2.0), out_ready=1 -> 2 cycles later out_s=0, out_e=9'd128, out_m=16'h4000.
REQ-032 a=16'h3FC0 (1.5), b=16'h3FC0 -> p=16'h9000 shifted, out_e=9'd128, out_m=16'h4800.
REQ-033 a=16'h7F00, b=16'h7F00 -> out_e=9'h100, out_m=0; with BF16_MULT_STATS_EN ovf_cnt=1.
REQ-034 a=16'h0080, b=16'h0080 -> out_e=0, out_m=0; with macro ftz_cnt=1; a=16'h8000 x 16'h3F80 -> out_s=1, out_e=0.
REQ-035 Stream 8 pairs back-to-back, out_ready low cycles 3-6 -> in_ready low after both stages fill, all 8 results emitted in order, none lost.
REQ-036 Assert rst_n low with 2 pairs in flight -> out_valid=0 immediately; after release no stale output appears.
